// File: rtl/motor_ramp_pkg.sv
// Shared definitions for the motor ramp sequencer: opcodes, command fields, FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package motor_ramp_pkg;

  // Command opcodes carried in cmd_data[9:8]
  localparam logic [1:0] OP_SET      = 2'b00;
  localparam logic [1:0] OP_SET_NOW  = 2'b01;
  localparam logic [1:0] OP_STOP     = 2'b10;
  localparam logic [1:0] OP_ALL_STOP = 2'b11;

  // Command word layout: [11:10] channel, [9:8] opcode, [7:0] value
  localparam int CMD_W       = 12;
  localparam int CMD_CH_LSB  = 10;
  localparam int CMD_CH_W    = 2;
  localparam int CMD_OP_LSB  = 8;
  localparam int CMD_OP_W    = 2;
  localparam int CMD_VAL_LSB = 0;
  localparam int CMD_VAL_W   = 8;

  // Sequencer states: IDLE takes commands, RAMP walks the channels
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running divider: pulses tick for one cycle every TICK_DIV clk_sys cycles.
// Latency: tick is high while the counter sits at TICK_DIV-1; counter wraps on that edge.
// Backpressure: none; runs unconditionally outside reset.
module ramp_tick_gen
  import motor_ramp_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk_sys,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap when the tick fires
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Command-driven duty sequencer: holds a target per motor channel and slews pwm_set toward it.
// Latency: register updates land on the edge after the handshake; ramp visits one channel per cycle.
// Backpressure: cmd_ready low for NCH cycles during each ramp pass. Optional watchdog: MOTOR_RAMP_WDOG_EN.
module motor_ramp_sequencer
  import motor_ramp_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DUTY_W   = 8,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 1000,
  parameter int WDOG_TKS = 250
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CMD_W-1:0]        cmd_data,
  output logic [NCH*DUTY_W-1:0]   pwm_set,
  output logic [NCH-1:0]          ch_busy,
  output logic                    wdog_trip,
  output logic                    cmd_err
);

  localparam int                IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);

  logic                           tick;
  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [NCH-1:0][DUTY_W-1:0]     cur_q;
  logic [NCH-1:0][DUTY_W-1:0]     tgt_q;

  logic [CMD_CH_W-1:0]            cmd_ch;
  logic [CMD_OP_W-1:0]            cmd_op;
  logic [DUTY_W-1:0]              cmd_val;
  logic                           ch_ok;
  logic                           cmd_fire;
  logic                           cmd_take;
  logic                           wdog_zero;

  logic [DUTY_W-1:0]              s_cur;
  logic [DUTY_W-1:0]              s_tgt;
  logic [DUTY_W-1:0]              s_gap;
  logic [DUTY_W-1:0]              s_next;

  ramp_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .tick    (tick)
  );

  assign cmd_ch   = cmd_data[CMD_CH_LSB +: CMD_CH_W];
  assign cmd_op   = cmd_data[CMD_OP_LSB +: CMD_OP_W];
  assign cmd_val  = DUTY_W'(cmd_data[CMD_VAL_LSB +: CMD_VAL_W]);
  assign ch_ok    = (32'(cmd_ch) < 32'(NCH));
  assign cmd_ready = (state == S_IDLE);
  assign cmd_fire = cmd_valid & cmd_ready;
  assign pwm_set  = cur_q;

  // One shared step unit, pointed at the channel selected by idx
  always_comb begin
    s_cur  = cur_q[idx];
    s_tgt  = tgt_q[idx];
    s_gap  = '0;
    s_next = s_cur;
    if (s_cur < s_tgt) begin
      s_gap  = s_tgt - s_cur;
      s_next = s_cur + ((s_gap > STEP_V) ? STEP_V : s_gap);
    end else if (s_cur > s_tgt) begin
      s_gap  = s_cur - s_tgt;
      s_next = s_cur - ((s_gap > STEP_V) ? STEP_V : s_gap);
    end
  end

  // A channel is busy until its live duty has caught up with its target
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      ch_busy[n] = (cur_q[n] != tgt_q[n]);
    end
  end

  // Sequencer FSM: wait for a tick in IDLE, then sweep idx across all channels
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_RAMP;
            idx   <= '0;
          end
        end
        S_RAMP: begin
          if (idx == LAST_IDX) begin
            state <= S_IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Live duty and targets: ramp writes only in RAMP, commands only land in IDLE
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cur_q <= '0;
      tgt_q <= '0;
    end else begin
      if (state == S_RAMP) begin
        cur_q[idx] <= s_next;
      end
      if (wdog_zero) begin
        tgt_q <= '0;
      end else if (cmd_take) begin
        case (cmd_op)
          OP_SET: begin
            if (ch_ok) tgt_q[cmd_ch] <= cmd_val;
          end
          OP_SET_NOW: begin
            if (ch_ok) begin
              tgt_q[cmd_ch] <= cmd_val;
              cur_q[cmd_ch] <= cmd_val;
            end
          end
          OP_STOP: begin
            if (ch_ok) tgt_q[cmd_ch] <= '0;
          end
          default: begin
            tgt_q <= '0;
          end
        endcase
      end
    end
  end

`ifdef MOTOR_RAMP_WDOG_EN
  localparam int WCW = $clog2(WDOG_TKS + 1);

  logic [WCW-1:0] wdog_cnt;
  logic           trip_q;
  logic           err_q;
  logic           cmd_drop;

  // While tripped only ALL_STOP is honoured; anything else is swallowed
  assign cmd_drop  = cmd_fire & trip_q & (cmd_op != OP_ALL_STOP);
  assign cmd_take  = cmd_fire & ~cmd_drop;
  // Trip on the tick that brings the idle count up to WDOG_TKS
  assign wdog_zero = tick & ~cmd_fire & ~trip_q & (wdog_cnt == WCW'(WDOG_TKS - 1));
  assign wdog_trip = trip_q;
  assign cmd_err   = err_q;

  // Watchdog: count idle ticks, trip and hold until ALL_STOP arrives
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wdog_cnt <= '0;
      trip_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= cmd_drop;
      if (cmd_fire) begin
        wdog_cnt <= '0;
        if (cmd_op == OP_ALL_STOP) trip_q <= 1'b0;
      end else if (wdog_zero) begin
        wdog_cnt <= WCW'(WDOG_TKS);
        trip_q   <= 1'b1;
      end else if (tick && !trip_q) begin
        wdog_cnt <= wdog_cnt + WCW'(1);
      end
    end
  end
`else
  assign cmd_take  = cmd_fire;
  assign wdog_zero = 1'b0;
  assign wdog_trip = 1'b0;
  assign cmd_err   = 1'b0;
`endif

endmodule
